// File: rtl/iagc_pkg.sv
// Shared state/status encodings and sample helpers for the IAGC sequencer.
// The status word is the state encoding itself, so the wrapper decodes it directly.
package iagc_pkg;

  localparam int ZMOD_W   = 14;
  localparam int STATUS_W = 4;

  typedef enum logic [STATUS_W-1:0] {
    ST_IDLE    = 4'b0000,
    ST_INIT    = 4'b0001,
    ST_MEASURE = 4'b0010,
    ST_DECIDE  = 4'b0011,
    ST_SETTLE  = 4'b0100,
    ST_ERROR   = 4'b1111
  } state_e;

  // Most-negative code has no positive twin; clamp it to full scale.
  function automatic logic [ZMOD_W-1:0] abs_sat(input logic signed [ZMOD_W-1:0] sample);
    logic [ZMOD_W-1:0] mag;
    if (sample == {1'b1, {(ZMOD_W-1){1'b0}}})
      mag = {1'b0, {(ZMOD_W-1){1'b1}}};
    else if (sample[ZMOD_W-1])
      mag = ZMOD_W'(-sample);
    else
      mag = ZMOD_W'(sample);
    return mag;
  endfunction

endpackage

// File: rtl/iagc_peak_detector.sv
// Windowed peak-magnitude accumulator: tracks max |sample| over 2^WINDOW_LOG2 beats.
// clear wins over beat, so a beat arriving on a discard cycle is dropped with the window.
module iagc_peak_detector
  import iagc_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              beat_i,
  input  logic              clear_i,
  input  logic [ZMOD_W-1:0] sample_i,
  output logic [ZMOD_W-1:0] acc_o,
  output logic              window_done_o
);

  localparam logic [WINDOW_LOG2:0] LAST_BEAT = {1'b0, {WINDOW_LOG2{1'b1}}};

  logic [WINDOW_LOG2:0] cnt_q;
  logic [ZMOD_W-1:0]    acc_q;
  logic [ZMOD_W-1:0]    mag;

  assign mag           = abs_sat(sample_i);
  assign acc_o         = acc_q;
  assign window_done_o = beat_i && !clear_i && (cnt_q == LAST_BEAT);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (beat_i) begin
      cnt_q <= cnt_q + 1'b1;
      if (mag > acc_q) acc_q <= mag;
    end
  end

endmodule

// File: rtl/iagc_controller.sv
// IAGC sequencer: ADC init wait, windowed peak measurement, hysteretic gain switch, relay settle.
// state | meaning: IDLE park/ADC reset, INIT await init_done, MEASURE take window,
// DECIDE publish peak + pick gain, SETTLE relay wait, ERROR init timeout.
module iagc_controller
  import iagc_pkg::*;
#(
  parameter int AXIS_DATA_SIZE      = 32,
  parameter int ZMOD_DATA_SIZE      = 14,
  parameter int IAGC_STATUS_SIZE    = 4,
  parameter int WINDOW_LOG2         = 10,
  parameter int INIT_TIMEOUT_CYCLES = 1000000,
  parameter int SETTLE_CYCLES       = 1000
) (
  input  logic                        i_sys_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_adc_init_done,
  input  logic [AXIS_DATA_SIZE-1:0]   i_adc_data,
  input  logic                        i_adc_data_valid,
  output logic                        o_adc_ready,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_thr_high,
  input  logic [ZMOD_DATA_SIZE-1:0]   i_thr_low,
  output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
  output logic                        o_gain_high,
  output logic [ZMOD_DATA_SIZE-1:0]   o_peak,
  output logic                        o_peak_valid,
  output logic                        o_error
);

  localparam int TO_W = (INIT_TIMEOUT_CYCLES > 1) ? $clog2(INIT_TIMEOUT_CYCLES) : 1;
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(INIT_TIMEOUT_CYCLES - 1);
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);

  state_e              state_q;
  logic                ready_q;
  logic                gain_high_q;
  logic [ZMOD_W-1:0]   peak_q;
  logic                peak_valid_q;
  logic                error_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [ST_W-1:0]     settle_cnt_q;

  logic                beat;
  logic                clear;
  logic                window_done;
  logic [ZMOD_W-1:0]   acc;
  logic [ZMOD_W-1:0]   ch1_sample;
  logic                unused_adc_bits;

  assign ch1_sample      = i_adc_data[AXIS_DATA_SIZE-1 -: ZMOD_DATA_SIZE];
  assign unused_adc_bits = ^i_adc_data[AXIS_DATA_SIZE-ZMOD_DATA_SIZE-1:0];

  // Any cycle outside an active, healthy MEASURE throws the partial window away.
  assign beat  = i_adc_data_valid && ready_q;
  assign clear = (state_q != ST_MEASURE) || !i_enable || !i_adc_init_done;

  iagc_peak_detector #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_peak (
    .clk_i         (i_sys_clock),
    .reset_i       (i_reset),
    .beat_i        (beat),
    .clear_i       (clear),
    .sample_i      (ch1_sample),
    .acc_o         (acc),
    .window_done_o (window_done)
  );

  always_ff @(posedge i_sys_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      gain_high_q  <= 1'b1;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
      error_q      <= 1'b0;
      to_cnt_q     <= '0;
      settle_cnt_q <= '0;
    end else begin
      peak_valid_q <= 1'b0;
      if (!i_enable) begin
        state_q <= ST_IDLE;
        ready_q <= 1'b0;
        error_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_INIT;
            to_cnt_q <= '0;
          end
          ST_INIT: begin
            if (i_adc_init_done) begin
              state_q <= ST_MEASURE;
              ready_q <= 1'b1;
            end else if (to_cnt_q == TO_LAST) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          ST_MEASURE: begin
            if (!i_adc_init_done) begin
              state_q  <= ST_INIT;
              ready_q  <= 1'b0;
              to_cnt_q <= '0;
            end else if (window_done) begin
              state_q <= ST_DECIDE;
              ready_q <= 1'b0;
            end
          end
          ST_DECIDE: begin
            peak_q       <= acc;
            peak_valid_q <= 1'b1;
            if (gain_high_q && (acc >= i_thr_high)) begin
              gain_high_q  <= 1'b0;
              state_q      <= ST_SETTLE;
              settle_cnt_q <= '0;
            end else if (!gain_high_q && (acc < i_thr_low)) begin
              gain_high_q  <= 1'b1;
              state_q      <= ST_SETTLE;
              settle_cnt_q <= '0;
            end else begin
              state_q <= ST_MEASURE;
              ready_q <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_q <= ST_MEASURE;
              ready_q <= 1'b1;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          ST_ERROR: begin
            error_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            error_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_iagc_status = state_q;
  assign o_adc_ready   = ready_q;
  assign o_gain_high   = gain_high_q;
  assign o_peak        = peak_q;
  assign o_peak_valid  = peak_valid_q;
  assign o_error       = error_q;

endmodule
